// File: rtl/iserdes_pkg.sv
// Shared types and constants for the ISERDES word-alignment controller.
package iserdes_pkg;

  localparam int PIX_W = 12;
  localparam logic [PIX_W-1:0] TRAIN_WORD_DEF = 12'hF00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } align_state_t;

endpackage

// File: rtl/iserdes_align_ctrl.sv
// Word-alignment FSM: slips the ISERDES until the training word frames,
// declares lock, and retrains automatically on sustained mismatches.
module iserdes_align_ctrl
  import iserdes_pkg::*;
#(
  parameter logic [PIX_W-1:0] TRAIN_WORD    = TRAIN_WORD_DEF,
  parameter int               SETTLE_CYCLES = 4,
  parameter int               MATCH_COUNT   = 16,
  parameter int               MAX_SLIPS     = 12,
  parameter int               LOSS_COUNT    = 4
) (
  input  logic             clk_div_out,
  input  logic             rst,
  input  logic             serdes_rdy,
  input  logic             start,
  input  logic             track_en,
  input  logic [PIX_W-1:0] data_in,
  output logic             bitslip,
  output logic             busy,
  output logic             aligned,
  output logic             align_err,
  output logic             lock_lost,
  output logic [3:0]       slip_count
);

  localparam int WAIT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int MATCH_W = $clog2(MATCH_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

  localparam logic [WAIT_W-1:0]  WAIT_LOAD = WAIT_W'(SETTLE_CYCLES - 1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(MATCH_COUNT);
  localparam logic [MISS_W-1:0]  MISS_MAX  = MISS_W'(LOSS_COUNT);
  localparam logic [3:0]         SLIP_MAX  = 4'(MAX_SLIPS);

  align_state_t       state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [MISS_W-1:0]  miss_cnt;
  logic               word_ok;

  assign word_ok = (data_in == TRAIN_WORD);

  function automatic logic [WAIT_W-1:0] wait_dec(input logic [WAIT_W-1:0] v);
    return (v == '0) ? v : v - WAIT_W'(1);
  endfunction

  function automatic logic [MATCH_W-1:0] match_inc(input logic [MATCH_W-1:0] v);
    return (v == MATCH_MAX) ? v : v + MATCH_W'(1);
  endfunction

  function automatic logic [MISS_W-1:0] miss_inc(input logic [MISS_W-1:0] v);
    return (v == MISS_MAX) ? v : v + MISS_W'(1);
  endfunction

  function automatic logic [3:0] slip_inc(input logic [3:0] v);
    return (v == SLIP_MAX) ? v : v + 4'd1;
  endfunction

  // Outputs are written together with the next state so they always
  // describe the state being entered.
  always_ff @(posedge clk_div_out or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      slip_count <= '0;
      bitslip    <= 1'b0;
      busy       <= 1'b0;
      aligned    <= 1'b0;
      align_err  <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      bitslip   <= 1'b0;
      lock_lost <= 1'b0;
      if (!serdes_rdy) begin
        // slip_count is deliberately kept for post-mortem debug
        state     <= ST_IDLE;
        busy      <= 1'b0;
        aligned   <= 1'b0;
        align_err <= 1'b0;
        match_cnt <= '0;
        miss_cnt  <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              state      <= ST_SETTLE;
              wait_cnt   <= WAIT_LOAD;
              slip_count <= '0;
              busy       <= 1'b1;
            end
          end
          ST_SETTLE: begin
            if (wait_cnt == '0) begin
              state     <= ST_CHECK;
              match_cnt <= '0;
            end else begin
              wait_cnt <= wait_dec(wait_cnt);
            end
          end
          ST_CHECK: begin
            if (word_ok) begin
              match_cnt <= match_inc(match_cnt);
              if (match_inc(match_cnt) == MATCH_MAX) begin
                state    <= ST_LOCKED;
                busy     <= 1'b0;
                aligned  <= 1'b1;
                miss_cnt <= '0;
              end
            end else if (slip_count < SLIP_MAX) begin
              state      <= ST_SLIP;
              bitslip    <= 1'b1;
              slip_count <= slip_inc(slip_count);
            end else begin
              state     <= ST_FAIL;
              busy      <= 1'b0;
              align_err <= 1'b1;
            end
          end
          ST_SLIP: begin
            state    <= ST_SETTLE;
            wait_cnt <= WAIT_LOAD;
          end
          ST_LOCKED: begin
            if (start) begin
              state      <= ST_SETTLE;
              wait_cnt   <= WAIT_LOAD;
              slip_count <= '0;
              busy       <= 1'b1;
              aligned    <= 1'b0;
              miss_cnt   <= '0;
            end else if (!track_en || word_ok) begin
              miss_cnt <= '0;
            end else if (miss_inc(miss_cnt) == MISS_MAX) begin
              state      <= ST_SETTLE;
              wait_cnt   <= WAIT_LOAD;
              slip_count <= '0;
              busy       <= 1'b1;
              aligned    <= 1'b0;
              lock_lost  <= 1'b1;
              miss_cnt   <= '0;
            end else begin
              miss_cnt <= miss_inc(miss_cnt);
            end
          end
          ST_FAIL: begin
            if (start) begin
              state      <= ST_SETTLE;
              wait_cnt   <= WAIT_LOAD;
              slip_count <= '0;
              busy       <= 1'b1;
              align_err  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
